// File: rtl/tc_ram_2r1w.sv
// Two-read, one-write RAM with per-byte write mask.
// A sequential clear engine zeroes the array after reset or on request.
module tc_ram_2r1w #(
  parameter int    UUID      = 0,
  parameter string NAME      = "",
  parameter int    WIDTH     = 8,
  parameter int    ADDR_BITS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load0,
  input  logic [ADDR_BITS-1:0]   address0,
  output logic [WIDTH-1:0]       out0,
  input  logic                   load1,
  input  logic [ADDR_BITS-1:0]   address1,
  output logic [WIDTH-1:0]       out1,
  input  logic                   save,
  input  logic [ADDR_BITS-1:0]   save_address,
  input  logic [WIDTH/8-1:0]     save_mask,
  input  logic [WIDTH-1:0]       in,
  input  logic                   clear,
  output logic                   busy
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int LANES = WIDTH / 8;

  typedef enum logic [1:0] {
    RESET,
    CLEAR,
    IDLE
  } state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] clr_ptr;
  logic [WIDTH-1:0]     mem [DEPTH];
  logic                 write;
  logic                 unused_params;

  assign unused_params = (UUID == 0) ^ (NAME == "");

  assign busy  = (state != IDLE);
  assign write = (state == IDLE) && save && !clear;

  // The first edge after reset release already clears word 0, so the
  // whole sequence takes exactly DEPTH edges. The array has no reset
  // value; rst only holds it untouched.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state   <= RESET;
      clr_ptr <= '0;
    end else begin
      unique case (state)
        RESET, CLEAR: begin
          mem[clr_ptr] <= '0;
          clr_ptr      <= clr_ptr + ADDR_BITS'(1);
          state        <= (clr_ptr == '1) ? IDLE : CLEAR;
        end
        IDLE: begin
          if (clear) begin
            state   <= CLEAR;
            clr_ptr <= '0;
          end else if (write) begin
            for (int k = 0; k < LANES; k++) begin
              if (save_mask[k]) begin
                mem[save_address][8*k +: 8] <= in[8*k +: 8];
              end
            end
          end
        end
        default: state <= RESET;
      endcase
    end
  end

  assign out0 = (load0 && !busy) ? mem[address0] : '0;
  assign out1 = (load1 && !busy) ? mem[address1] : '0;

endmodule

// File: tb/tb_tc_ram_2r1w.sv
// Bench for tc_ram_2r1w: abstract model checked every rising edge,
// plus directed scenarios with literal expectations.
module tb_tc_ram_2r1w;

  localparam int W = 16;
  localparam int A = 4;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load0 = 1'b0;
  logic         load1 = 1'b0;
  logic         save = 1'b0;
  logic         clear = 1'b0;
  logic         busy;
  logic [A-1:0] address0 = '0;
  logic [A-1:0] address1 = '0;
  logic [A-1:0] save_address = '0;
  logic [1:0]   save_mask = '0;
  logic [W-1:0] in = '0;
  logic [W-1:0] out0;
  logic [W-1:0] out1;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;
  int n;

  logic [W-1:0] mmem [D];
  int           remaining = D;

  tc_ram_2r1w #(
    .UUID(7),
    .NAME("ram_under_test"),
    .WIDTH(W),
    .ADDR_BITS(A)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load0(load0),
    .address0(address0),
    .out0(out0),
    .load1(load1),
    .address1(address1),
    .out1(out1),
    .save(save),
    .save_address(save_address),
    .save_mask(save_mask),
    .in(in),
    .clear(clear),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a clear zeroes everything at once and then just counts
  // down the edges during which the array is unavailable.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      remaining = D;
      foreach (mmem[i]) mmem[i] = '0;
    end else if (remaining > 0) begin
      remaining--;
    end else if (clear) begin
      remaining = D;
      foreach (mmem[i]) mmem[i] = '0;
    end else if (save) begin
      for (int k = 0; k < 2; k++)
        if (save_mask[k]) mmem[save_address][8*k +: 8] = in[8*k +: 8];
    end
  end

  always @(posedge clk) begin
    if (started) begin
      logic mb;
      mb = rst || (remaining > 0);
      chk("model_busy", W'(busy), W'(mb));
      chk("model_out0", out0, (load0 && !mb) ? mmem[address0] : '0);
      chk("model_out1", out1, (load1 && !mb) ? mmem[address1] : '0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [A-1:0] a, input logic [W-1:0] d,
                    input logic [1:0] m);
    save = 1'b1;
    save_address = a;
    in = d;
    save_mask = m;
    cyc();
    save = 1'b0;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      cnt++;
      if (!busy) break;
    end
  endtask

  initial begin
    cyc();
    cyc();
    started = 1'b1;
    load0 = 1'b1;
    load1 = 1'b1;
    address1 = 4'd5;
    #1;
    chk("reset_busy", W'(busy), 16'd1);
    chk("reset_out0", out0, 16'h0000);
    chk("reset_out1", out1, 16'h0000);

    rst = 1'b0;
    count_busy(n);
    chk("reset_clear_len", W'(n), 16'd16);
    for (int a = 0; a < D; a++) begin
      address0 = A'(a);
      address1 = A'(D - 1 - a);
      #1;
      chk("cleared_out0", out0, 16'h0000);
      chk("cleared_out1", out1, 16'h0000);
    end
    cyc();

    wr(4'd3, 16'hABCD, 2'b11);
    wr(4'd3, 16'h1234, 2'b01);
    address0 = 4'd3;
    #1;
    chk("masked_write", out0, 16'hAB34);
    load0 = 1'b0;
    #1;
    chk("load0_off", out0, 16'h0000);

    wr(4'd5, 16'h5555, 2'b11);
    wr(4'd9, 16'hAAAA, 2'b11);
    load0 = 1'b1;
    address0 = 4'd5;
    address1 = 4'd9;
    #1;
    chk("dual_out0", out0, 16'h5555);
    chk("dual_out1", out1, 16'hAAAA);
    save = 1'b1;
    save_address = 4'd9;
    in = 16'h0F0F;
    save_mask = 2'b11;
    #1;
    chk("before_edge", out1, 16'hAAAA);
    @(negedge clk);
    #1;
    chk("after_edge", out1, 16'h0F0F);
    save = 1'b0;
    cyc();

    clear = 1'b1;
    save = 1'b1;
    save_address = 4'd2;
    in = 16'hFFFF;
    cyc();
    clear = 1'b0;
    save = 1'b0;
    chk("clear_busy", W'(busy), 16'd1);
    count_busy(n);
    chk("clear_len", W'(n), 16'd16);
    address0 = 4'd2;
    #1;
    chk("clear_wins", out0, 16'h0000);
    address0 = 4'd3;
    #1;
    chk("clear_zeroed", out0, 16'h0000);
    chk("clear_zeroed1", out1, 16'h0000);
    cyc();

    wr(4'd7, 16'h1234, 2'b11);
    address0 = 4'd7;
    #1;
    chk("pre_block", out0, 16'h1234);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    repeat (3) cyc();
    chk("busy_mid", W'(busy), 16'd1);
    chk("busy_read", out0, 16'h0000);
    save = 1'b1;
    save_address = 4'd7;
    in = 16'h7777;
    save_mask = 2'b11;
    clear = 1'b1;
    cyc();
    save = 1'b0;
    clear = 1'b0;
    count_busy(n);
    chk("no_restart_len", W'(n), 16'd12);
    #1;
    chk("dropped_save", out0, 16'h0000);
    cyc();

    wr(4'd4, 16'h4444, 2'b11);
    address0 = 4'd4;
    #1;
    chk("idle_pre_rst", out0, 16'h4444);
    rst = 1'b1;
    #1;
    chk("async_busy", W'(busy), 16'd1);
    chk("async_out0", out0, 16'h0000);
    cyc();
    rst = 1'b0;
    count_busy(n);
    chk("rst_idle_len", W'(n), 16'd16);
    cyc();

    clear = 1'b1;
    cyc();
    clear = 1'b0;
    repeat (5) cyc();
    rst = 1'b1;
    #1;
    chk("mid_busy", W'(busy), 16'd1);
    chk("mid_out0", out0, 16'h0000);
    chk("mid_out1", out1, 16'h0000);
    cyc();
    rst = 1'b0;
    count_busy(n);
    chk("mid_rst_len", W'(n), 16'd16);
    #1;
    chk("final_read", out0, 16'h0000);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
